// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and helpers for vga_sync_gen and vga_pixel_tick.
// Default timing is 640x480@60 Hz at a 25 MHz pixel rate derived from a 50 MHz clk.
package vga_timing_pkg;

    localparam int DEF_CLK_DIV  = 2;
    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Full line length in pixels.
    function automatic int h_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Full frame length in lines.
    function automatic int v_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

    // Sync pulse windows for the default timing: start inclusive, end exclusive.
    localparam int DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
    localparam int DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
    localparam int DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
    localparam int DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

    // True when a 10-bit scan position lies in [start, end).
    function automatic logic in_window(input logic [9:0] pos, input int start, input int stop);
        return (int'(pos) >= start) && (int'(pos) < stop);
    endfunction

endpackage

// File: rtl/vga_pixel_tick.sv
// Clock-enable divider: pix_en is a registered one-clk pulse every CLK_DIV clks.
// pix_adv is high in the clk before pix_en rises so that registers updated on
// that edge present their new value in the same cycle as pix_en.
module vga_pixel_tick
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV = DEF_CLK_DIV
)(
    input  logic clk,
    input  logic resetn,
    output logic pix_en,
    output logic pix_adv
);

    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

    logic [DW-1:0] r_div;
    logic          r_pix_en;
    logic [DW-1:0] w_div_next;

    assign w_div_next = (r_div == DIV_LAST) ? '0 : r_div + 1'b1;
    assign pix_adv    = (w_div_next == DIV_LAST);
    assign pix_en     = r_pix_en;

    // Divider count and the registered enable that marks div == CLK_DIV-1.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_div    <= '0;
            r_pix_en <= 1'b0;
        end else begin
            r_div    <= w_div_next;
            r_pix_en <= pix_adv;
        end
    end

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster timing generator: x/y scan counters, bright, hsync/vsync and a
// per-frame tick. All outputs are registered from the next x/y so they
// describe the same pixel in the same cycle.
// Build option VGA_SYNC_ALIGN_EN: delays hsync/vsync by one extra clk so they
// line up with the registered colour outputs of the downstream bit generator.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV  = DEF_CLK_DIV,
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
)(
    input  logic       clk,
    input  logic       resetn,
    output logic       pix_en,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       bright,
    output logic       hsync,
    output logic       vsync,
    output logic       frame_tick
);

    localparam int H_TOTAL  = h_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL  = v_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = HS_START + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = VS_START + V_SYNC;

    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
    localparam logic [9:0] V_ACT_LAST = 10'(V_ACTIVE - 1);

    logic       w_pix_adv;
    logic [9:0] r_x;
    logic [9:0] r_y;
    logic       r_bright;
    logic       r_hsync;
    logic       r_vsync;
    logic       r_frame_tick;
    logic [9:0] w_x_next;
    logic [9:0] w_y_next;
    logic       w_line_end;

    vga_pixel_tick #(
        .CLK_DIV (CLK_DIV)
    ) u_tick (
        .clk     (clk),
        .resetn  (resetn),
        .pix_en  (pix_en),
        .pix_adv (w_pix_adv)
    );

    assign w_line_end = (r_x == H_LAST);
    assign w_x_next   = w_line_end ? 10'd0 : r_x + 10'd1;
    assign w_y_next   = !w_line_end ? r_y : ((r_y == V_LAST) ? 10'd0 : r_y + 10'd1);

    // Scan counters and pixel decode, all advanced together on the pixel edge.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_x          <= H_LAST;
            r_y          <= V_LAST;
            r_bright     <= 1'b0;
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= 1'b0;
            if (w_pix_adv) begin
                r_x          <= w_x_next;
                r_y          <= w_y_next;
                r_bright     <= (int'(w_x_next) < H_ACTIVE) && (int'(w_y_next) < V_ACTIVE);
                r_hsync      <= !in_window(w_x_next, HS_START, HS_END);
                r_vsync      <= !in_window(w_y_next, VS_START, VS_END);
                r_frame_tick <= w_line_end && (r_y == V_ACT_LAST);
            end
        end
    end

    assign x          = r_x;
    assign y          = r_y;
    assign bright     = r_bright;
    assign frame_tick = r_frame_tick;

`ifdef VGA_SYNC_ALIGN_EN
    logic r_hsync_d;
    logic r_vsync_d;

    // One extra clk on the syncs so they match the registered colour path.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_hsync_d <= 1'b1;
            r_vsync_d <= 1'b1;
        end else begin
            r_hsync_d <= r_hsync;
            r_vsync_d <= r_vsync;
        end
    end

    assign hsync = r_hsync_d;
    assign vsync = r_vsync_d;
`else
    assign hsync = r_hsync;
    assign vsync = r_vsync;
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: a default-timing instance checked against a table of
// hand-computed points along the first lines, plus a small-timing instance
// (CLK_DIV=1, 15x10 raster) used for whole-frame, frame_tick and mid-frame reset checks.
module tb_vga_sync_gen;

`ifdef VGA_SYNC_ALIGN_EN
    localparam int LAG = 1;
`else
    localparam int LAG = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       resetn_a, resetn_b;
    logic       pe_a, br_a, hs_a, vs_a, ft_a;
    logic [9:0] x_a, y_a;
    logic       pe_b, br_b, hs_b, vs_b, ft_b;
    logic [9:0] x_b, y_b;

    vga_sync_gen dut_a (
        .clk(clk), .resetn(resetn_a), .pix_en(pe_a), .x(x_a), .y(y_a),
        .bright(br_a), .hsync(hs_a), .vsync(vs_a), .frame_tick(ft_a)
    );

    // Small raster: H 8+2+3+2=15 (hsync low x=10..12), V 6+1+2+1=10 (vsync low y=7..8).
    vga_sync_gen #(
        .CLK_DIV(1), .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_b (
        .clk(clk), .resetn(resetn_b), .pix_en(pe_b), .x(x_b), .y(y_b),
        .bright(br_b), .hsync(hs_b), .vsync(vs_b), .frame_tick(ft_b)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // k = posedges since resetn_a release; hs_al = hsync expected with the extra sync stage.
    typedef struct {
        int   k;
        logic pe;
        int   x;
        int   y;
        logic br;
        logic hs;
        logic hs_al;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int k;
        int n_pe, n_hs, n_br, n_vs, n_ft, n_ft_bad;
        int first_x, first_h, first_v0, first_vs;
        int guard;
        logic exp_hs;

        vecs[0]  = '{1,    1'b1, 0,   0, 1'b1, 1'b1, 1'b1};
        vecs[1]  = '{2,    1'b0, 0,   0, 1'b1, 1'b1, 1'b1};
        vecs[2]  = '{1279, 1'b1, 639, 0, 1'b1, 1'b1, 1'b1};
        vecs[3]  = '{1281, 1'b1, 640, 0, 1'b0, 1'b1, 1'b1};
        vecs[4]  = '{1311, 1'b1, 655, 0, 1'b0, 1'b1, 1'b1};
        vecs[5]  = '{1313, 1'b1, 656, 0, 1'b0, 1'b0, 1'b1};
        vecs[6]  = '{1314, 1'b0, 656, 0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1504, 1'b0, 751, 0, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{1505, 1'b1, 752, 0, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{1599, 1'b1, 799, 0, 1'b0, 1'b1, 1'b1};
        vecs[10] = '{1601, 1'b1, 0,   1, 1'b1, 1'b1, 1'b1};
        vecs[11] = '{1602, 1'b0, 0,   1, 1'b1, 1'b1, 1'b1};

        resetn_a = 1'b0;
        resetn_b = 1'b0;
        repeat (3) @(negedge clk);

        // Reset state of both instances.
        chk("rst_a_x", x_a, 799);   chk("rst_a_y", y_a, 524);
        chk("rst_a_pe", pe_a, 0);   chk("rst_a_br", br_a, 0);
        chk("rst_a_hs", hs_a, 1);   chk("rst_a_vs", vs_a, 1);
        chk("rst_a_ft", ft_a, 0);
        chk("rst_b_x", x_b, 14);    chk("rst_b_y", y_b, 9);
        chk("rst_b_pe", pe_b, 0);
        $display("reset: a=(%0d,%0d) b=(%0d,%0d)", x_a, y_a, x_b, y_b);

        // Table-driven points along the first line and a half of the default raster.
        resetn_a = 1'b1;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            while (k < vecs[i].k) begin
                @(negedge clk);
                k++;
            end
            exp_hs = (LAG != 0) ? vecs[i].hs_al : vecs[i].hs;
            chk($sformatf("v%0d_pe", i), pe_a, vecs[i].pe);
            chk($sformatf("v%0d_x", i),  x_a,  vecs[i].x);
            chk($sformatf("v%0d_y", i),  y_a,  vecs[i].y);
            chk($sformatf("v%0d_br", i), br_a, vecs[i].br);
            chk($sformatf("v%0d_hs", i), hs_a, exp_hs);
            chk($sformatf("v%0d_vs", i), vs_a, 1);
            chk($sformatf("v%0d_ft", i), ft_a, 0);
            $display("vec %0d: k=%0d pe=%0d x=%0d y=%0d br=%0d hs=%0d", i, k, pe_a, x_a, y_a, br_a, hs_a);
        end

        // One full line of the default raster: 1600 clks starting after (0,1).
        n_pe = 0; n_hs = 0; n_br = 0; first_x = -1; first_h = -1;
        for (int i = 0; i < 1600; i++) begin
            @(negedge clk);
            k++;
            if (pe_a) begin
                n_pe++;
                if (!hs_a) n_hs++;
                if (br_a)  n_br++;
            end
            if (x_a == 10'd656 && first_x < 0) first_x = k;
            if (!hs_a && first_h < 0) first_h = k;
        end
        chk("line_pix_en", n_pe, 800);
        chk("line_hs_low", n_hs, 96);
        chk("line_bright", n_br, 640);
        chk("line_hs_lag", first_h - first_x, LAG);
        $display("line: pix_en=%0d hs_low=%0d bright=%0d hs_lag=%0d", n_pe, n_hs, n_br, first_h - first_x);

        // Small raster: run to (5,3), then reset mid-frame for 3 clks.
        resetn_b = 1'b1;
        guard = 0;
        do begin
            @(negedge clk);
            guard++;
        end while (!(x_b == 10'd5 && y_b == 10'd3) && guard < 300);
        chk("mid_reach_guard", guard, 51);
        resetn_b = 1'b0;
        #1;
        chk("mid_rst_x", x_b, 14);  chk("mid_rst_y", y_b, 9);
        chk("mid_rst_pe", pe_b, 0); chk("mid_rst_br", br_b, 0);
        chk("mid_rst_hs", hs_b, 1); chk("mid_rst_vs", vs_b, 1);
        repeat (3) @(negedge clk);
        chk("mid_hold_x", x_b, 14); chk("mid_hold_pe", pe_b, 0);
        chk("mid_hold_ft", ft_b, 0);
        $display("mid reset: held at (%0d,%0d)", x_b, y_b);
        resetn_b = 1'b1;

        // Three whole frames from the restart; first clk must be pixel (0,0).
        n_pe = 0; n_hs = 0; n_br = 0; n_vs = 0; n_ft = 0; n_ft_bad = 0;
        first_v0 = -1; first_vs = -1;
        for (int i = 0; i < 450; i++) begin
            @(negedge clk);
            if (i == 0) begin
                chk("restart_x", x_b, 0);  chk("restart_y", y_b, 0);
                chk("restart_pe", pe_b, 1); chk("restart_br", br_b, 1);
            end
            if (pe_b) n_pe++;
            if (br_b) n_br++;
            if (!hs_b) n_hs++;
            if (!vs_b) n_vs++;
            if (ft_b) begin
                n_ft++;
                if (!(x_b == 10'd0 && y_b == 10'd6 && pe_b)) n_ft_bad++;
            end
            if (x_b == 10'd0 && y_b == 10'd7 && first_v0 < 0) first_v0 = i;
            if (!vs_b && first_vs < 0) first_vs = i;
        end
        chk("frm_pix_en", n_pe, 450);
        chk("frm_bright", n_br, 144);
        chk("frm_hs_low", n_hs, 90);
        chk("frm_vs_low", n_vs, 90);
        chk("frm_ticks", n_ft, 3);
        chk("frm_tick_pos", n_ft_bad, 0);
        chk("frm_vs_lag", first_vs - first_v0, LAG);
        $display("frames: pix_en=%0d bright=%0d hs_low=%0d vs_low=%0d ticks=%0d", n_pe, n_br, n_hs, n_vs, n_ft);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
